// File: rtl/ama_riscv_pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/JALR redirect flush,
// post-reset pipeline clear sequence and saturating stall/flush event counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RST_SEQ | staged clearing of ID/EX/MEM after reset, hazards ignored
// RUN     | normal issue; load-use stall or redirect detection
// FLUSH   | second bubble of a redirect (synchronous imem latency)
module ama_riscv_pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_inst_ex,
  input  logic [4:0]  rd_ex,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        rs1_used_id,
  input  logic        rs2_used_id,
  input  logic        branch_inst_id,
  input  logic        bc_taken_id,
  input  logic        bp_taken_id,
  input  logic        jalr_id,
  input  logic        cnt_clr,
  output logic        stall_if,
  output logic        stall_id,
  output logic        clear_if,
  output logic        clear_id,
  output logic        clear_ex,
  output logic        clear_mem,
  output logic        pc_we,
  output logic        rst_seq_done,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RST_SEQ = 2'd0,
    RUN     = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  rst_seq_q, rst_seq_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        load_use;
  logic        flush_req;
  logic        stall_ev;
  logic        flush_ev;

  assign load_use = load_inst_ex && (rd_ex != 5'd0) &&
                    ((rs1_used_id && (rs1_id == rd_ex)) ||
                     (rs2_used_id && (rs2_id == rd_ex)));

  assign flush_req = (branch_inst_id && (bc_taken_id != bp_taken_id)) || jalr_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RST_SEQ;
      rst_seq_q   <= 3'b111;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      rst_seq_q   <= rst_seq_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rst_seq_d    = rst_seq_q;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    clear_if     = 1'b0;
    clear_id     = 1'b0;
    clear_ex     = 1'b0;
    clear_mem    = 1'b0;
    pc_we        = 1'b1;
    rst_seq_done = 1'b0;
    stall_ev     = 1'b0;
    flush_ev     = 1'b0;

    case (state_q)
      RST_SEQ: begin
        rst_seq_d = {rst_seq_q[1:0], 1'b0};
        clear_id  = rst_seq_q[0];
        clear_ex  = rst_seq_q[1];
        clear_mem = rst_seq_q[2];
        if (rst_seq_d == 3'b000) state_d = RUN;
      end
      RUN: begin
        rst_seq_done = 1'b1;
        // Load-use wins; a pending redirect is seen again once the bubble clears.
        if (load_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          clear_ex = 1'b1;
          pc_we    = 1'b0;
          stall_ev = 1'b1;
        end else if (flush_req) begin
          clear_if = 1'b1;
          flush_ev = 1'b1;
          state_d  = FLUSH;
        end
      end
      FLUSH: begin
        rst_seq_done = 1'b1;
        clear_if     = 1'b1;
        state_d      = RUN;
      end
      default: state_d = RST_SEQ;
    endcase

    // Reset is visible on the outputs immediately, not only after the flops settle.
    if (!rst) begin
      stall_if     = 1'b0;
      stall_id     = 1'b0;
      clear_if     = 1'b1;
      clear_id     = 1'b1;
      clear_ex     = 1'b1;
      clear_mem    = 1'b1;
      pc_we        = 1'b1;
      rst_seq_done = 1'b0;
      stall_ev     = 1'b0;
      flush_ev     = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = 16'd0;
      flush_cnt_d = 16'd0;
    end else begin
      if (stall_ev && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
      if (flush_ev && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ama_riscv_pipe_ctrl.sv
// Scoreboard bench for ama_riscv_pipe_ctrl: directed vectors push expected
// outputs at each negedge; a monitor pops and compares a little later.
module tb_ama_riscv_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_inst_ex;
  logic [4:0]  rd_ex, rs1_id, rs2_id;
  logic        rs1_used_id, rs2_used_id;
  logic        branch_inst_id, bc_taken_id, bp_taken_id, jalr_id;
  logic        cnt_clr;
  logic        stall_if, stall_id, clear_if, clear_id, clear_ex, clear_mem;
  logic        pc_we, rst_seq_done;
  logic [15:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // {stall_if, stall_id, clear_if, clear_id, clear_ex, clear_mem, pc_we, rst_seq_done}
  localparam logic [7:0] F_RESET = 8'b0011_1110;
  localparam logic [7:0] F_S111  = 8'b0001_1110;
  localparam logic [7:0] F_S110  = 8'b0000_1110;
  localparam logic [7:0] F_S100  = 8'b0000_0110;
  localparam logic [7:0] F_RUN   = 8'b0000_0011;
  localparam logic [7:0] F_STALL = 8'b1100_1001;
  localparam logic [7:0] F_FLUSH = 8'b0010_0011;

  logic [7:0]  q_flags[$];
  logic [15:0] q_sc[$];
  logic [15:0] q_fc[$];
  string       q_name[$];

  ama_riscv_pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .load_inst_ex(load_inst_ex), .rd_ex(rd_ex),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .branch_inst_id(branch_inst_id), .bc_taken_id(bc_taken_id),
    .bp_taken_id(bp_taken_id), .jalr_id(jalr_id),
    .cnt_clr(cnt_clr),
    .stall_if(stall_if), .stall_id(stall_id), .clear_if(clear_if),
    .clear_id(clear_id), .clear_ex(clear_ex), .clear_mem(clear_mem),
    .pc_we(pc_we), .rst_seq_done(rst_seq_done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Monitor: samples 2 time units after each negedge, once inputs have settled.
  always @(negedge clk) begin
    logic [7:0]  ef, af;
    logic [15:0] es, ef_c;
    string       nm;
    #2;
    if (q_flags.size() > 0) begin
      ef   = q_flags.pop_front();
      es   = q_sc.pop_front();
      ef_c = q_fc.pop_front();
      nm   = q_name.pop_front();
      af   = {stall_if, stall_id, clear_if, clear_id, clear_ex, clear_mem, pc_we, rst_seq_done};
      n_tests++;
      if (af !== ef || stall_cnt !== es || flush_cnt !== ef_c) begin
        n_fail++;
        $display("FAIL %s: got flags=%b sc=%h fc=%h, expected flags=%b sc=%h fc=%h",
                 nm, af, stall_cnt, flush_cnt, ef, es, ef_c);
      end
    end
  end

  task automatic idle();
    load_inst_ex = 0; rd_ex = 0; rs1_id = 0; rs2_id = 0;
    rs1_used_id = 0; rs2_used_id = 0;
    branch_inst_id = 0; bc_taken_id = 0; bp_taken_id = 0; jalr_id = 0;
    cnt_clr = 0;
  endtask

  task automatic set_lu_rs2(input logic [4:0] r);
    load_inst_ex = 1; rd_ex = r; rs2_id = r; rs2_used_id = 1;
  endtask

  // Called just after a negedge with inputs driven; waits for the next negedge.
  task automatic chk(input string nm, input logic [7:0] f, input logic [15:0] sc,
                     input logic [15:0] fc);
    q_flags.push_back(f);
    q_sc.push_back(sc);
    q_fc.push_back(fc);
    q_name.push_back(nm);
    @(negedge clk);
  endtask

  initial begin
    rst = 0;
    idle();
    @(negedge clk);
    chk("reset_a", F_RESET, 0, 0);
    chk("reset_b", F_RESET, 0, 0);

    rst = 1;
    chk("seq111", F_S111, 0, 0);
    set_lu_rs2(5'd5); jalr_id = 1;
    chk("seq110_ignore_hazard", F_S110, 0, 0);
    idle();
    chk("seq100", F_S100, 0, 0);
    chk("run_first", F_RUN, 0, 0);

    set_lu_rs2(5'd5);
    chk("load_use_rs2", F_STALL, 0, 0);
    idle();
    chk("after_stall", F_RUN, 1, 0);
    set_lu_rs2(5'd0);
    chk("rd_zero_no_stall", F_RUN, 1, 0);
    idle();
    load_inst_ex = 1; rd_ex = 7; rs1_id = 7; rs1_used_id = 1; rs2_id = 7;
    chk("load_use_rs1", F_STALL, 1, 0);
    idle();
    load_inst_ex = 1; rd_ex = 7; rs1_id = 7; rs2_id = 7;
    chk("rs_not_used", F_RUN, 2, 0);

    idle(); branch_inst_id = 1; bc_taken_id = 1; bp_taken_id = 0;
    chk("mispredict_run", F_FLUSH, 2, 0);
    idle();
    chk("mispredict_flush", F_FLUSH, 2, 1);
    chk("mispredict_done", F_RUN, 2, 1);
    branch_inst_id = 1; bc_taken_id = 1; bp_taken_id = 1;
    chk("predicted_ok", F_RUN, 2, 1);

    idle(); jalr_id = 1;
    chk("jalr_run", F_FLUSH, 2, 1);
    idle(); set_lu_rs2(5'd9); jalr_id = 1;
    chk("flush_ignores_hazards", F_FLUSH, 2, 2);
    idle();
    chk("jalr_done", F_RUN, 2, 2);

    set_lu_rs2(5'd3); jalr_id = 1;
    chk("prio_stall", F_STALL, 2, 2);
    idle(); jalr_id = 1;
    chk("prio_then_flush", F_FLUSH, 3, 2);
    idle();
    chk("prio_flush2", F_FLUSH, 3, 3);
    cnt_clr = 1;
    chk("clr_issue", F_RUN, 3, 3);
    cnt_clr = 0;
    chk("clr_done", F_RUN, 0, 0);

    set_lu_rs2(5'd12);
    repeat (65535) @(negedge clk);
    chk("sat_reach", F_STALL, 16'hFFFF, 0);
    chk("sat_hold", F_STALL, 16'hFFFF, 0);
    cnt_clr = 1;
    chk("clr_vs_stall", F_STALL, 16'hFFFF, 0);
    idle();
    chk("clr_vs_stall_done", F_RUN, 0, 0);

    set_lu_rs2(5'd4);
    chk("stall_pre_rst", F_STALL, 0, 0);
    rst = 0;
    chk("rst_mid_stall", F_RESET, 0, 0);
    idle(); rst = 1;
    chk("seq111_b", F_S111, 0, 0);
    chk("seq110_b", F_S110, 0, 0);
    chk("seq100_b", F_S100, 0, 0);
    jalr_id = 1;
    chk("jalr_b", F_FLUSH, 0, 0);
    idle(); rst = 0;
    chk("rst_mid_flush", F_RESET, 0, 0);
    rst = 1;
    chk("seq111_c", F_S111, 0, 0);

    for (int i = 0; i < 10 && q_flags.size() > 0; i++) @(negedge clk);
    #5;
    if (q_flags.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q_flags.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ama_riscv_pipe_ctrl.md
AMA_RISCV_PIPE_CTRL -- requirements
Module: ama_riscv_pipe_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port: load_inst_ex  input  1  instruction in EX is a load.
REQ-004 SHALL have port: rd_ex  input  5  destination register of EX instruction.
REQ-005 SHALL have ports: rs1_id, rs2_id  input  5 each  source registers of ID instruction.
REQ-006 SHALL have ports: rs1_used_id, rs2_used_id  input  1 each  ID instruction reads rs1/rs2.
REQ-007 SHALL have ports: branch_inst_id, bc_taken_id, bp_taken_id  input  1 each  ID branch flag, resolved outcome, predicted outcome.
REQ-008 SHALL have port: jalr_id  input  1  ID instruction is JALR.
REQ-009 SHALL have port: cnt_clr  input  1  synchronous clear of performance counters.
REQ-010 SHALL have outputs: stall_if, stall_id, clear_if, clear_id, clear_ex, clear_mem, pc_we, rst_seq_done  1 each.
REQ-011 SHALL have outputs: stall_cnt, flush_cnt  16 each  saturating event counters.

Function
REQ-012 SHALL implement FSM states RST_SEQ, RUN, FLUSH; outputs are combinational from state, rst_seq[2:0] and current inputs.
REQ-013 SHALL, in RST_SEQ, update rst_seq <= {rst_seq[1:0],1'b0} each cycle; clear_id=rst_seq[0], clear_ex=rst_seq[1], clear_mem=rst_seq[2], clear_if=0, stall_*=0, pc_we=1.
REQ-014 SHALL transition RST_SEQ->RUN on the cycle after rst_seq reaches 3'b000 is registered (sequence 111,110,100,000 = 3 cycles of RST_SEQ with nonzero clears, then RUN); all hazard inputs ignored in RST_SEQ.
REQ-015 SHALL assert rst_seq_done=1 only in RUN and FLUSH.
REQ-016 SHALL define load_use = load_inst_ex & (rd_ex!=0) & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
REQ-017 SHALL, in RUN with load_use=1, drive stall_if=1, stall_id=1, pc_we=0, clear_ex=1 in that cycle and stay in RUN (1-cycle bubble).
REQ-018 SHALL define flush_req = (branch_inst_id & (bc_taken_id != bp_taken_id)) | jalr_id.
REQ-019 SHALL, in RUN with flush_req=1 and load_use=0, drive clear_if=1, pc_we=1 and go to FLUSH.
REQ-020 SHALL, in FLUSH, drive clear_if=1, pc_we=1, ignore load_use and flush_req, and return to RUN next cycle (2-bubble redirect for synchronous imem).
REQ-021 SHALL give load_use priority over flush_req in the same cycle; flush_req is re-evaluated after the stall.
REQ-022 SHALL, in RUN without events, drive all stall/clear outputs 0 and pc_we=1.
REQ-023 SHALL increment stall_cnt on each cycle of REQ-017 and flush_cnt on each RUN->FLUSH transition, saturating at 16'hFFFF.
REQ-024 SHALL clear both counters to 0 when cnt_clr=1; cnt_clr wins over a simultaneous increment.

Reset
REQ-025 SHALL, while rst=0 (asynchronously, from any state), force state=RST_SEQ, rst_seq=3'b111, stall_cnt=flush_cnt=0.
REQ-026 SHALL, while rst=0, drive clear_if=clear_id=clear_ex=clear_mem=1, stall_if=stall_id=0, pc_we=1, rst_seq_done=0.
REQ-027 SHALL, on rst assertion mid-FLUSH or mid-stall, abandon the operation with no counter update.

Verification
REQ-028 Release rst -> clear_id high 1 cycle, clear_ex 2, clear_mem 3; rst_seq_done=1 on 4th cycle.
REQ-029 RUN, load_inst_ex=1, rd_ex=5, rs2_used_id=1, rs2_id=5 -> stall_if=stall_id=clear_ex=1, pc_we=0 one cycle; stall_cnt=1.
REQ-030 Same with rd_ex=0 -> no stall, stall_cnt unchanged.
REQ-031 branch_inst_id=1, bc_taken_id=1, bp_taken_id=0 -> clear_if=1 for 2 cycles, flush_cnt=1; jalr_id=1 gives identical result.
REQ-032 load_use and flush_req same cycle -> stall only; next cycle (load_use=0, flush_req=1) -> flush.
REQ-033 Preload stall_cnt=16'hFFFF, another stall -> stays FFFF; cnt_clr with stall -> 0; rst pulse in FLUSH -> immediate reset values.
